// File: rtl/serial_adder_if.sv
// Handshake and result bus between a requester and serial_adder.
// Optional signed-overflow flag present only when SERIAL_ADDER_OVF_EN is defined.
interface serial_adder_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             c_out;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf;

    modport master (
        output start, a, b, c_in,
        input  busy, done, sum, c_out, ovf
    );

    modport slave (
        input  start, a, b, c_in,
        output busy, done, sum, c_out, ovf
    );
`else
    modport master (
        output start, a, b, c_in,
        input  busy, done, sum, c_out
    );

    modport slave (
        input  start, a, b, c_in,
        output busy, done, sum, c_out
    );
`endif
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell iterated WIDTH times, LSB first,
// with a registered carry. Parallel sum/c_out are presented with a done pulse.
// Optional feature macro: SERIAL_ADDER_OVF_EN adds the signed-overflow output.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_adder_if.slave  bus
);
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;

    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] sum_sh_q;
    logic [WIDTH-1:0] sum_q;
    logic [CNT_W-1:0] cnt_q;
    logic             carry_q;
    logic             c_out_q;
    logic             busy_q;
    logic             done_q;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q;
`endif

    logic             load_c;
    logic             step_c;
    logic             last_c;
    logic             bit_c;
    logic             carry_nxt_c;
    logic [WIDTH:0]   sum_cat_c;

    // Full-adder cell on the current LSBs and the registered carry.
    assign bit_c       = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    assign carry_nxt_c = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);
    // New sum bit enters at the MSB while the partial sum shifts right.
    assign sum_cat_c   = {bit_c, sum_sh_q};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath control decode.
    always_comb begin
        state_d = state_q;
        load_c  = 1'b0;
        step_c  = 1'b0;
        last_c  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    load_c  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                step_c = 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    last_c  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operand shift registers, carry and bit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
        end else if (load_c) begin
            a_sh_q  <= bus.a;
            b_sh_q  <= bus.b;
            carry_q <= bus.c_in;
            cnt_q   <= '0;
        end else if (step_c) begin
            a_sh_q   <= a_sh_q >> 1;
            b_sh_q   <= b_sh_q >> 1;
            sum_sh_q <= sum_cat_c[WIDTH:1];
            carry_q  <= carry_nxt_c;
            cnt_q    <= cnt_q + CNT_W'(1);
        end
    end

    // Registered outputs; results load only on the edge that enters DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            busy_q <= (state_d != IDLE);
            done_q <= (state_d == DONE);
            if (last_c) begin
                sum_q   <= sum_cat_c[WIDTH:1];
                c_out_q <= carry_nxt_c;
`ifdef SERIAL_ADDER_OVF_EN
                // carry_q here is the carry into the MSB position.
                ovf_q   <= carry_q ^ carry_nxt_c;
`endif
            end
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.sum   = sum_q;
    assign bus.c_out = c_out_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign bus.ovf   = ovf_q;
`endif

endmodule
